johnson_seq_ctrl: RTL and testbench



---
 rtl/johnson_pkg.sv | 42 ++++
 rtl/johnson_tick_gen.sv | 31 +++
 rtl/johnson_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson counter sequencer.
//   - cmd_op_e     : command opcodes carried on cmd_op
//   - seq_state_e  : sequencer FSM states
//   - JC_WIDTH     : default Johnson register width
//   - is_johnson_legal() : legality check for a counter value
package johnson_pkg;

  localparam int unsigned JC_WIDTH = 8;
  // Widest counter the legality helper can inspect.
  localparam int unsigned JC_MAX_W = 32;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_BURST = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST,
    ST_STEP,
    ST_RECOVER
  } seq_state_e;

  // A Johnson state is a thermometer code (ones packed at the LSB side) or
  // its complement. Both forms have at most one boundary between adjacent
  // bits, and every pattern with at most one boundary is one of them, so
  // counting boundaries within the low `width` bits is sufficient.
  function automatic logic is_johnson_legal(input logic [JC_MAX_W-1:0] state,
                                            input int unsigned         width);
    int unsigned edges;
    edges = 0;
    for (int unsigned i = 0; i + 1 < JC_MAX_W; i++) begin
      if ((i + 1 < width) && (state[i] != state[i+1]))
        edges++;
    end
    return (edges <= 1);
  endfunction

endpackage

// File: rtl/johnson_tick_gen.sv
// Step-rate prescaler for the Johnson sequencer.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, zeroes the prescaler
//   clr  - synchronous restart of the prescaler from zero
//   div  - tick period minus one, sampled continuously
//   tick - high in the cycle where the count equals div
module johnson_tick_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = (count == div);

  // If div is lowered below the current count, the count simply runs on
  // and wraps; it is never clamped.
  always_ff @(posedge clk) begin
    if (rst || clr || tick)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequencer and command front-end for the Johnson counter datapath.
// Accepts RUN/STOP/STEP/BURST commands over valid/ready, divides the clock
// into step ticks and drives step/direction/clear strobes into the counter.
// Illegal (non-Johnson) counter values seen while running cause a one-cycle
// clear, a sticky error flag and a return to idle.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   cmd_valid  - command present
//   cmd_ready  - command accepted when cmd_valid && cmd_ready
//   cmd_op     - 0=RUN 1=STOP 2=STEP 3=BURST
//   cmd_dir    - 0=shift toward MSB, 1=reverse
//   cmd_len    - BURST step count
//   div        - tick period minus one
//   jc_state   - counter value fed back from the datapath
//   jc_step    - one-cycle advance strobe (registered)
//   jc_dir     - direction presented with jc_step
//   jc_clear   - one-cycle clear strobe (registered)
//   busy       - high in any state other than idle
//   done       - one-cycle completion pulse
//   err        - sticky illegal-state flag, cleared only by rst
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH   = JC_WIDTH,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic               cmd_dir,
  input  logic [BURST_W-1:0] cmd_len,
  input  logic [DIV_W-1:0]   div,
  input  logic [WIDTH-1:0]   jc_state,
  output logic               jc_step,
  output logic               jc_dir,
  output logic               jc_clear,
  output logic               busy,
  output logic               done,
  output logic               err
);

  seq_state_e         state;
  logic [BURST_W-1:0] burst_cnt;
  cmd_op_e            op;
  logic               accept;
  logic               stop_req;
  logic               presc_clr;
  logic               tick;
  logic               jc_legal;

  assign op       = cmd_op_e'(cmd_op);
  assign accept   = cmd_valid && cmd_ready;
  assign stop_req = accept && (op == CMD_STOP);

  // Restart the prescaler on entry to RUN/BURST so the first step lands
  // div+1 cycles after acceptance.
  assign presc_clr = accept && (state == ST_IDLE) &&
                     ((op == CMD_RUN) || ((op == CMD_BURST) && (cmd_len != '0)));

  assign jc_legal = is_johnson_legal(JC_MAX_W'(jc_state), WIDTH);

  johnson_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .div  (div),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      jc_step   <= 1'b0;
      jc_clear  <= 1'b0;
      jc_dir    <= 1'b0;
    end else begin
      jc_step  <= 1'b0;
      jc_clear <= 1'b0;
      done     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op != CMD_STOP)
              jc_dir <= cmd_dir;
            case (op)
              CMD_RUN: begin
                state <= ST_RUN;
                busy  <= 1'b1;
              end
              CMD_STEP: begin
                state     <= ST_STEP;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
                jc_step   <= 1'b1;
                done      <= 1'b1;
              end
              CMD_BURST: begin
                if (cmd_len == '0) begin
                  done <= 1'b1;
                end else begin
                  state     <= ST_BURST;
                  busy      <= 1'b1;
                  burst_cnt <= cmd_len;
                end
              end
              default: ;
            endcase
          end
        end

        // A burst whose last step has been issued sits here for one cycle
        // with burst_cnt==0 so that done trails the final step by a cycle.
        ST_RUN, ST_BURST: begin
          if (!jc_legal) begin
            state     <= ST_RECOVER;
            cmd_ready <= 1'b0;
            err       <= 1'b1;
            jc_clear  <= 1'b1;
            burst_cnt <= '0;
          end else if (stop_req || ((state == ST_BURST) && (burst_cnt == '0))) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            burst_cnt <= '0;
          end else if (tick) begin
            jc_step <= 1'b1;
            if (state == ST_BURST)
              burst_cnt <= burst_cnt - 1'b1;
          end
        end

        ST_STEP, ST_RECOVER: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;
  import johnson_pkg::*;

  localparam int W    = 8;
  localparam int DW   = 16;
  localparam int BW   = 8;
  localparam int NSEQ = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          cmd_dir;
  logic [BW-1:0] cmd_len;
  logic [DW-1:0] div;
  logic [W-1:0]  jc_state;
  logic          jc_step, jc_dir, jc_clear, busy, done, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  johnson_seq_ctrl #(
    .WIDTH   (W),
    .DIV_W   (DW),
    .BURST_W (BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dir   (cmd_dir),
    .cmd_len   (cmd_len),
    .div       (div),
    .jc_state  (jc_state),
    .jc_step   (jc_step),
    .jc_dir    (jc_dir),
    .jc_clear  (jc_clear),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Datapath stand-in: the Johnson register driven by the DUT strobes,
  // with an override used to inject an illegal value.
  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;
  always @(posedge clk) begin
    if (rst)           jc_state <= '0;
    else if (force_en) jc_state <= force_val;
    else if (jc_clear) jc_state <= '0;
    else if (jc_step)  jc_state <= jc_dir ? {~jc_state[0], jc_state[W-1:1]}
                                          : {jc_state[W-2:0], ~jc_state[W-1]};
  end

  // Reference: the 2W legal states listed in forward order; the counter
  // position is an index into that list.
  logic [W-1:0] seq [NSEQ];
  int ref_idx = 0;

  function automatic int advance(input int idx, input logic d, input int n);
    int t;
    t = d ? idx - n : idx + n;
    return ((t % NSEQ) + NSEQ) % NSEQ;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle. Cycle 0 is the cycle
  // following the accepting edge.
  task automatic run_cmd(input logic [1:0] op, input logic d, input int len, input int dv,
                         input int stop_at, input int budget,
                         output int nst, output int fst, output int lst,
                         output int dcyc, output int nd, output int derr, output int busy0);
    nst = 0; fst = -1; lst = -1; dcyc = -1; nd = 0; derr = 0; busy0 = -1;
    check("ready_when_idle", 32'(cmd_ready), 1);
    div = DW'(dv); cmd_op = op; cmd_dir = d; cmd_len = BW'(len); cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 0) busy0 = int'(busy);
      if (jc_step) begin
        nst++;
        if (fst < 0) fst = c;
        lst = c;
        if (jc_dir !== d) derr++;
      end
      if (done) begin
        nd++;
        if (dcyc < 0) dcyc = c;
      end
      if (c == stop_at) begin
        cmd_op = CMD_STOP; cmd_valid = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic       dir;
    int         len;
    int         dv;
    int         e_steps;
    int         e_first;
    int         e_last;
    int         e_done;
    int         e_busy0;
    logic [7:0] e_jc;
  } vec_t;

  vec_t vecs [7];

  int nst, fst, lst, dcyc, nd, derr, busy0;
  int e_st, e_f, e_l, e_d, e_b0;
  int r, k, len, dv;
  logic d;
  logic [1:0] op;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NSEQ; i++) begin
      if (i <= W) seq[i] = W'((1 << i) - 1);
      else        seq[i] = W'(((1 << W) - 1) << (i - W));
    end

    vecs[0] = '{CMD_STEP,  1'b1, 0, 5, 1, 0,  0,  0, 1, 8'h00};
    vecs[1] = '{CMD_BURST, 1'b0, 5, 3, 5, 4, 20, 21, 1, 8'h1F};
    vecs[2] = '{CMD_BURST, 1'b1, 0, 2, 0, -1, -1, 0, 0, 8'h1F};
    vecs[3] = '{CMD_STEP,  1'b1, 0, 0, 1, 0,  0,  0, 1, 8'h0F};
    vecs[4] = '{CMD_BURST, 1'b0, 3, 0, 3, 1,  3,  4, 1, 8'h7F};
    vecs[5] = '{CMD_BURST, 1'b0, 2, 1, 2, 2,  4,  5, 1, 8'hFE};
    vecs[6] = '{CMD_BURST, 1'b1, 4, 2, 4, 3, 12, 13, 1, 8'h1F};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dir = 1'b0; cmd_len = '0; div = '0;

    // Reset held two cycles, then a single step from 0x00.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", {cmd_ready, jc_step, jc_dir, jc_clear, busy, done, err}, 7'b1000000);
    run_cmd(CMD_STEP, 1'b0, 0, 0, -1, 4, nst, fst, lst, dcyc, nd, derr, busy0);
    check("t1_steps", nst, 1);
    check("t1_step_cycle", fst, 0);
    check("t1_done_cycle", dcyc, 0);
    check("t1_busy_c0", busy0, 1);
    check("t1_dir", derr, 0);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_jc", jc_state, 8'h01);
    ref_idx = 1;

    // Table-driven single commands.
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].op, vecs[i].dir, vecs[i].len, vecs[i].dv, -1, vecs[i].e_done + 5,
              nst, fst, lst, dcyc, nd, derr, busy0);
      check($sformatf("v%0d_steps", i), nst, vecs[i].e_steps);
      check($sformatf("v%0d_first", i), fst, vecs[i].e_first);
      check($sformatf("v%0d_last", i), lst, vecs[i].e_last);
      check($sformatf("v%0d_done", i), dcyc, vecs[i].e_done);
      check($sformatf("v%0d_ndone", i), nd, 1);
      check($sformatf("v%0d_dir", i), derr, 0);
      check($sformatf("v%0d_busy0", i), busy0, vecs[i].e_busy0);
      check($sformatf("v%0d_jc", i), jc_state, vecs[i].e_jc);
      ref_idx = advance(ref_idx, vecs[i].dir, vecs[i].e_steps);
    end

    // RUN at div=0, STOP presented in cycle 10: the tick due in that cycle
    // must not produce a step.
    run_cmd(CMD_RUN, 1'b0, 0, 0, 10, 15, nst, fst, lst, dcyc, nd, derr, busy0);
    check("t3_steps", nst, 10);
    check("t3_first", fst, 1);
    check("t3_last", lst, 10);
    check("t3_done", dcyc, 11);
    check("t3_ndone", nd, 1);
    ref_idx = advance(ref_idx, 1'b0, 10);
    check("t3_jc", jc_state, seq[ref_idx]);

    // Randomized commands against the index-based reference.
    for (int n = 0; n < 40; n++) begin
      r   = $urandom_range(0, 2);
      d   = 1'($urandom_range(0, 1));
      dv  = $urandom_range(0, 3);
      len = $urandom_range(0, 10);
      k   = $urandom_range(0, 12);
      if (r == 0) begin
        op = CMD_STEP; e_st = 1; e_f = 0; e_l = 0; e_d = 0; e_b0 = 1; k = -1;
      end else if (r == 1) begin
        op = CMD_BURST; k = -1;
        if (len == 0) begin
          e_st = 0; e_f = -1; e_l = -1; e_d = 0; e_b0 = 0;
        end else begin
          e_st = len; e_f = dv + 1; e_l = len * (dv + 1); e_d = e_l + 1; e_b0 = 1;
        end
      end else begin
        op = CMD_RUN;
        e_st = k / (dv + 1);
        e_f = (e_st > 0) ? dv + 1 : -1;
        e_l = (e_st > 0) ? e_st * (dv + 1) : -1;
        e_d = k + 1; e_b0 = 1;
      end
      run_cmd(op, d, len, dv, k, e_d + 5, nst, fst, lst, dcyc, nd, derr, busy0);
      check($sformatf("r%0d_steps", n), nst, e_st);
      check($sformatf("r%0d_first", n), fst, e_f);
      check($sformatf("r%0d_last", n), lst, e_l);
      check($sformatf("r%0d_done", n), dcyc, e_d);
      check($sformatf("r%0d_ndone", n), nd, 1);
      check($sformatf("r%0d_dir", n), derr, 0);
      check($sformatf("r%0d_busy0", n), busy0, e_b0);
      ref_idx = advance(ref_idx, d, e_st);
      check($sformatf("r%0d_jc", n), jc_state, seq[ref_idx]);
    end

    // Illegal state during RUN.
    div = DW'(7); cmd_op = CMD_RUN; cmd_dir = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    force_val = 8'h5A; force_en = 1'b1;
    @(posedge clk);
    #1 force_en = 1'b0;
    @(negedge clk);
    check("t5_pre_clear", {jc_clear, err, busy, done}, 4'b0010);
    check("t5_jc_forced", jc_state, 8'h5A);
    @(negedge clk);
    check("t5_recover", {jc_clear, err, busy, done, cmd_ready, jc_step}, 6'b111000);
    @(negedge clk);
    check("t5_idle", {jc_clear, err, busy, done, cmd_ready}, 5'b01001);
    check("t5_jc_cleared", jc_state, 8'h00);
    ref_idx = 0;
    run_cmd(CMD_STEP, 1'b0, 0, 0, -1, 4, nst, fst, lst, dcyc, nd, derr, busy0);
    check("t5_step_after", nst, 1);
    check("t5_err_sticky", 32'(err), 1);
    ref_idx = advance(ref_idx, 1'b0, 1);

    // Reset in the middle of a long burst.
    run_cmd(CMD_BURST, 1'b1, 200, 1, -1, 20, nst, fst, lst, dcyc, nd, derr, busy0);
    check("t6_steps_before", nst, 9);
    check("t6_no_done", nd, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_reset_outputs", {cmd_ready, jc_step, jc_dir, jc_clear, busy, done, err}, 7'b1000000);
    run_cmd(CMD_STEP, 1'b0, 0, 0, -1, 4, nst, fst, lst, dcyc, nd, derr, busy0);
    check("t6_step_steps", nst, 1);
    check("t6_step_done", dcyc, 0);
    check("t6_jc", jc_state, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
